tm1638_key_event: RTL and testbench

- Consumes the raw 8-bit key vector produced by the TM1638 LED/key driver, which is refreshed once per display frame.
- Debounces each key and detects press/release edges.
- Optionally generates auto-repeat for held keys.
- Queues the resulting events in a small FIFO, read by the control logic through a valid/ready handshake.

---
 rtl/tm1638_key_event.sv | 165 ++++++++++++++++
 tb/tb_tm1638_key_event.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tm1638_key_event.sv
// tm1638_key_event: debounces the TM1638 key vector, captures press/release edges and queues them in a show-ahead FIFO.
// Define TM1638_KEY_AUTO_REPEAT_EN to build auto-repeat events for the lowest held key.
module tm1638_key_event #(
  parameter int C_FCK        = 48_000_000,
  parameter int C_FSAMPLE    = 1_000,
  parameter int C_DEB_N      = 4,
  parameter int C_FIFO_DEPTH = 8,
  parameter int C_RPT_DLY    = 500,
  parameter int C_RPT_PER    = 100
) (
  input  logic       CK_i,
  input  logic       XARST_i,
  input  logic [7:0] KEYS_i,
  output logic [4:0] EVT_o,
  output logic       EVT_VALID_o,
  input  logic       EVT_READY_i,
  output logic [7:0] KEYS_STABLE_o,
  output logic       OVF_o,
  input  logic       OVF_CLR_i
);
  localparam int C_DIV = C_FCK / C_FSAMPLE;
  localparam int DW = $clog2(C_DIV);
  localparam int AW = $clog2(C_FIFO_DEPTH);

  logic [DW-1:0] div_q, div_d;
  logic [7:0] s1_q, s2_q, stable_q, stable_d, press_pend_q, press_pend_d, rel_pend_q, rel_pend_d;
  logic [3:0] deb_q [8];
  logic [3:0] deb_d [8];
  logic [4:0] mem_q [C_FIFO_DEPTH];
  logic [4:0] mem_d [C_FIFO_DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic ovf_q, ovf_d;
  logic tick, empty, full, pop, push, can_push, ovf_set;
  logic [4:0] evt;
  logic [2:0] p_idx, r_idx;
  logic [7:0] rise, fall, p_clr, r_clr;
  logic rpt_pend, rpt_ovf;
  logic [2:0] rpt_idx;

  assign tick  = div_q == DW'(C_DIV - 1);
  assign empty = wr_q == rd_q;
  assign full  = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
  assign pop   = ~empty & EVT_READY_i;
  assign can_push = ~full | pop;

  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    stable_d = stable_q;
    for (int i = 0; i < 8; i++) begin
      deb_d[i] = deb_q[i];
      if (tick) begin
        deb_d[i] = (s2_q[i] == stable_q[i]) ? 4'd0 : deb_q[i] + 4'd1;
        if (deb_d[i] == 4'(C_DEB_N)) begin
          stable_d[i] = ~stable_q[i];
          deb_d[i] = 4'd0;
        end
      end
    end
    rise = stable_d & ~stable_q;
    fall = ~stable_d & stable_q;
    p_idx = '0;
    r_idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (press_pend_q[i]) p_idx = 3'(i);
      if (rel_pend_q[i]) r_idx = 3'(i);
    end
    push = can_push & (rpt_pend | (|press_pend_q) | (|rel_pend_q));
    evt = rpt_pend ? {2'b11, rpt_idx} : (|press_pend_q) ? {2'b01, p_idx} : {2'b00, r_idx};
    p_clr = (can_push & ~rpt_pend & (|press_pend_q)) ? 8'b1 << p_idx : '0;
    r_clr = (can_push & ~rpt_pend & ~(|press_pend_q) & (|rel_pend_q)) ? 8'b1 << r_idx : '0;
    // An edge on a key whose same-type event is still queued merges into it
    ovf_set = (|(rise & press_pend_q & ~p_clr)) | (|(fall & rel_pend_q & ~r_clr)) | rpt_ovf;
    press_pend_d = (press_pend_q & ~p_clr) | rise;
    rel_pend_d = (rel_pend_q & ~r_clr) | fall;
    ovf_d = (ovf_q & ~OVF_CLR_i) | ovf_set;
    wr_d = wr_q + (AW+1)'(push);
    rd_d = rd_q + (AW+1)'(pop);
    mem_d = mem_q;
    if (push) mem_d[wr_q[AW-1:0]] = evt;
  end

`ifdef TM1638_KEY_AUTO_REPEAT_EN
  localparam int RW = $clog2(C_RPT_DLY + C_RPT_PER + 1);
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic rpt_run_q, rpt_run_d, rpt_pend_q, rpt_pend_d, rpt_fire, rpt_push;
  logic [2:0] rpt_idx_q, rpt_idx_d, h_idx;

  assign rpt_pend = rpt_pend_q;
  assign rpt_idx  = rpt_idx_q;

  always_comb begin
    h_idx = '0;
    for (int i = 7; i >= 0; i--) if (stable_q[i]) h_idx = 3'(i);
    rpt_cnt_d = rpt_cnt_q;
    rpt_run_d = rpt_run_q;
    rpt_fire = 1'b0;
    if (stable_d != stable_q) begin
      rpt_cnt_d = '0;
      rpt_run_d = 1'b0;
    end else if (tick & (|stable_q)) begin
      rpt_cnt_d = rpt_cnt_q + 1'b1;
      rpt_fire = rpt_cnt_d == (rpt_run_q ? RW'(C_RPT_PER) : RW'(C_RPT_DLY));
      if (rpt_fire) begin
        rpt_cnt_d = '0;
        rpt_run_d = 1'b1;
      end
    end
    rpt_push = can_push & rpt_pend_q;
    rpt_ovf = rpt_fire & rpt_pend_q & ~rpt_push;
    rpt_pend_d = (rpt_pend_q & ~rpt_push) | rpt_fire;
    rpt_idx_d = rpt_fire ? h_idx : rpt_idx_q;
  end

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      rpt_cnt_q <= '0;
      rpt_run_q <= 1'b0;
      rpt_pend_q <= 1'b0;
      rpt_idx_q <= '0;
    end else begin
      rpt_cnt_q <= rpt_cnt_d;
      rpt_run_q <= rpt_run_d;
      rpt_pend_q <= rpt_pend_d;
      rpt_idx_q <= rpt_idx_d;
    end
  end
`else
  assign rpt_pend = 1'b0;
  assign rpt_idx  = '0;
  assign rpt_ovf  = 1'b0;
`endif

  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      div_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      stable_q <= '0;
      deb_q <= '{default: '0};
      press_pend_q <= '0;
      rel_pend_q <= '0;
      mem_q <= '{default: '0};
      wr_q <= '0;
      rd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      div_q <= div_d;
      s1_q <= KEYS_i;
      s2_q <= s1_q;
      stable_q <= stable_d;
      deb_q <= deb_d;
      press_pend_q <= press_pend_d;
      rel_pend_q <= rel_pend_d;
      mem_q <= mem_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      ovf_q <= ovf_d;
    end
  end

  assign EVT_o = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign EVT_VALID_o = ~empty;
  assign KEYS_STABLE_o = stable_q;
  assign OVF_o = ovf_q;
endmodule

// File: tb/tb_tm1638_key_event.sv
// tb_tm1638_key_event: directed and random stimulus checked every cycle against a queue-based event model.
module tb_tm1638_key_event;
  localparam int DIV = 16, DEB = 3, DEPTH = 4, DLY = 4, PER = 2;

  logic CK_i = 1'b0, XARST_i = 1'b0, EVT_READY_i = 1'b0, OVF_CLR_i = 1'b0;
  logic [7:0] KEYS_i = '0;
  logic [4:0] EVT_o;
  logic EVT_VALID_o, OVF_o;
  logic [7:0] KEYS_STABLE_o;
  int total = 0, bad = 0;

  tm1638_key_event #(
    .C_FCK(32), .C_FSAMPLE(2), .C_DEB_N(DEB), .C_FIFO_DEPTH(DEPTH),
    .C_RPT_DLY(DLY), .C_RPT_PER(PER)
  ) dut (
    .CK_i(CK_i), .XARST_i(XARST_i), .KEYS_i(KEYS_i), .EVT_o(EVT_o),
    .EVT_VALID_o(EVT_VALID_o), .EVT_READY_i(EVT_READY_i),
    .KEYS_STABLE_o(KEYS_STABLE_o), .OVF_o(OVF_o), .OVF_CLR_i(OVF_CLR_i)
  );

  always #5 CK_i = ~CK_i;

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: event queue plus per-key run lengths of disagreeing samples
  int div_n = 0, m_hold = 0, k = 0;
  int m_cnt [8];
  logic [7:0] sy1 = '0, sy2 = '0, m_stable = '0, m_pp = '0, m_rp = '0, ns, pp, rp;
  logic [4:0] m_q [$];
  logic m_ovf = 1'b0, m_rpend = 1'b0, tk, pop, can, set_ovf;
  logic [2:0] m_ridx = '0;

  initial forever begin
    @(posedge CK_i or negedge XARST_i);
    if (!XARST_i) begin
      div_n = 0; sy1 = '0; sy2 = '0; m_stable = '0; m_pp = '0; m_rp = '0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_q.delete(); m_ovf = 1'b0; m_rpend = 1'b0; m_ridx = '0; m_hold = 0;
    end else begin
      tk = div_n == DIV - 1;
      ns = m_stable; pp = m_pp; rp = m_rp; set_ovf = 1'b0;
      pop = m_q.size() > 0 && EVT_READY_i;
      can = m_q.size() < DEPTH || pop;
      if (tk) for (int i = 0; i < 8; i++) begin
        if (sy2[i] != m_stable[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == DEB) begin ns[i] = ~ns[i]; m_cnt[i] = 0; end
        end else m_cnt[i] = 0;
      end
      if (pop) void'(m_q.pop_front());
      if (can) begin
        if (m_rpend) begin m_q.push_back({2'b11, m_ridx}); m_rpend = 1'b0; end
        else if (pp != 0) begin k = lowest(pp); m_q.push_back({2'b01, 3'(k)}); pp[k] = 1'b0; end
        else if (rp != 0) begin k = lowest(rp); m_q.push_back({2'b00, 3'(k)}); rp[k] = 1'b0; end
      end
      for (int i = 0; i < 8; i++) begin
        if (ns[i] && !m_stable[i]) begin if (pp[i]) set_ovf = 1'b1; pp[i] = 1'b1; end
        if (!ns[i] && m_stable[i]) begin if (rp[i]) set_ovf = 1'b1; rp[i] = 1'b1; end
      end
`ifdef TM1638_KEY_AUTO_REPEAT_EN
      if (ns != m_stable) m_hold = 0;
      else if (tk && m_stable != 0) begin
        m_hold++;
        if (m_hold == DLY || (m_hold > DLY && (m_hold - DLY) % PER == 0)) begin
          if (m_rpend) set_ovf = 1'b1;
          m_rpend = 1'b1;
          m_ridx = 3'(lowest(m_stable));
        end
      end
`endif
      m_ovf = (m_ovf & ~OVF_CLR_i) | set_ovf;
      m_stable = ns; m_pp = pp; m_rp = rp;
      sy2 = sy1; sy1 = KEYS_i;
      div_n = tk ? 0 : div_n + 1;
    end
  end

  initial forever begin
    @(negedge CK_i);
    chk("evt", 8'(EVT_o), m_q.size() > 0 ? 8'(m_q[0]) : 8'h00);
    chk("valid", 8'(EVT_VALID_o), 8'(m_q.size() > 0));
    chk("stable", KEYS_STABLE_o, m_stable);
    chk("ovf", 8'(OVF_o), 8'(m_ovf));
  end

  task automatic cyc(input int n);
    repeat (n) begin @(negedge CK_i); #2; end
  endtask
  task automatic ticks(input int n);
    cyc(DIV * n);
  endtask
  task automatic pop1;
    EVT_READY_i = 1'b1; cyc(1); EVT_READY_i = 1'b0;
  endtask

  int n;
  int hold;

  initial begin
    cyc(3);
    chk("rst_evt", 8'(EVT_o), 8'h00);
    chk("rst_valid", 8'(EVT_VALID_o), 8'h00);
    chk("rst_stable", KEYS_STABLE_o, 8'h00);
    chk("rst_ovf", 8'(OVF_o), 8'h00);
    XARST_i = 1'b1;
    // press debounce
    KEYS_i = 8'h04; ticks(5);
    chk("press_stable", KEYS_STABLE_o, 8'h04);
    chk("press_valid", 8'(EVT_VALID_o), 8'h01);
    chk("press_evt", 8'(EVT_o), 8'b01010);
    pop1;
    chk("press_pop", 8'(EVT_VALID_o), 8'h00);
    KEYS_i = 8'h00; ticks(5); pop1;
    // glitch reject: at most two samples see the key
    KEYS_i = 8'h01; cyc(24); KEYS_i = 8'h00; ticks(4);
    chk("glitch_stable", KEYS_STABLE_o, 8'h00);
    chk("glitch_valid", 8'(EVT_VALID_o), 8'h00);
    // simultaneous edges
    KEYS_i = 8'h81; ticks(5);
    chk("sim_p0", 8'(EVT_o), 8'b01000); pop1;
    chk("sim_p7", 8'(EVT_o), 8'b01111); pop1;
    KEYS_i = 8'h00; ticks(5);
    chk("sim_r0", 8'(EVT_o), 8'b00000);
    chk("sim_r0_valid", 8'(EVT_VALID_o), 8'h01); pop1;
    chk("sim_r7", 8'(EVT_o), 8'b00111); pop1;
    chk("sim_empty", 8'(EVT_VALID_o), 8'h00);
    // FIFO full and overflow
    repeat (3) begin KEYS_i = 8'h04; ticks(5); KEYS_i = 8'h00; ticks(5); end
    chk("full_noovf", 8'(OVF_o), 8'h00);
    KEYS_i = 8'h04; ticks(5);
    chk("full_ovf", 8'(OVF_o), 8'h01);
    chk("full_head", 8'(EVT_o), 8'b01010);
    OVF_CLR_i = 1'b1; cyc(1); OVF_CLR_i = 1'b0;
    chk("ovf_clr", 8'(OVF_o), 8'h00);
    n = 0;
    while (EVT_VALID_o && n < 20) begin pop1; n++; end
    chk("drain_cnt", 8'(n), 8'd6);
    KEYS_i = 8'h00; ticks(5); pop1;
    chk("drain_empty", 8'(EVT_VALID_o), 8'h00);
    // reset mid-operation
    KEYS_i = 8'h81; ticks(5);
    chk("pre_rst_valid", 8'(EVT_VALID_o), 8'h01);
    KEYS_i = 8'h00; cyc(1);
    XARST_i = 1'b0; cyc(1);
    chk("mid_rst_valid", 8'(EVT_VALID_o), 8'h00);
    chk("mid_rst_evt", 8'(EVT_o), 8'h00);
    chk("mid_rst_stable", KEYS_STABLE_o, 8'h00);
    XARST_i = 1'b1; ticks(5);
    chk("post_rst_valid", 8'(EVT_VALID_o), 8'h00);
    // held key: auto-repeat only when built in
    KEYS_i = 8'h08; ticks(12);
    chk("hold_press", 8'(EVT_o), 8'b01011); pop1;
`ifdef TM1638_KEY_AUTO_REPEAT_EN
    chk("hold_rpt", 8'(EVT_o), 8'b11011);
`else
    chk("hold_norpt", 8'(EVT_VALID_o), 8'h00);
`endif
    KEYS_i = 8'h00; EVT_READY_i = 1'b1; ticks(5); EVT_READY_i = 1'b0;
    OVF_CLR_i = 1'b1; cyc(1); OVF_CLR_i = 1'b0;
    chk("hold_empty", 8'(EVT_VALID_o), 8'h00);
    // random key patterns with random back-pressure
    repeat (150) begin
      KEYS_i = 8'($urandom & $urandom);
      hold = $urandom_range(8, 80);
      repeat (hold) begin
        EVT_READY_i = $urandom_range(0, 3) == 0;
        OVF_CLR_i = $urandom_range(0, 31) == 0;
        cyc(1);
      end
    end
    EVT_READY_i = 1'b0; OVF_CLR_i = 1'b0; cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
